// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: access-width encoding,
// FSM state type and wait-counter width.
package mem_pkg;

    localparam logic [1:0] MEM_W_WORD = 2'd0;
    localparam logic [1:0] MEM_W_HALF = 2'd1;
    localparam logic [1:0] MEM_W_BYTE = 2'd2;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dm_state_e;

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane steering for the data memory: merges store data into
// the addressed lanes of a word and extracts/extends load data from a word.
module dm_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  width,
    input  logic        sign_ext,
    output logic [31:0] merged,
    output logic [31:0] rdata
);

    logic [15:0] half_s;
    logic [7:0]  byte_s;

    // Store path: only the addressed lanes take new data.
    always_comb begin
        merged = word;
        case (width)
            MEM_W_WORD: merged = wdata;
            MEM_W_HALF: begin
                if (lane[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            MEM_W_BYTE: begin
                case (lane)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            default: merged = word;
        endcase
    end

    // Load path: pick the lane, then sign- or zero-extend to 32 bits.
    always_comb begin
        half_s = lane[1] ? word[31:16] : word[15:0];
        case (lane)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            default: byte_s = word[31:24];
        endcase
        case (width)
            MEM_W_WORD: rdata = word;
            MEM_W_HALF: rdata = {{16{sign_ext & half_s[15]}}, half_s};
            MEM_W_BYTE: rdata = {{24{sign_ext & byte_s[7]}}, byte_s};
            default:    rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dm_responder.sv
// Stallable data-memory responder: one request at a time, WAIT_CYCLES wait
// states, then a held response. Define DM_WRITE_TRACE_EN for store tracing.
module dm_responder
    import mem_pkg::*;
#(
    parameter int          ADDR_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    input  logic [1:0]  ReqWidth,
    input  logic        ReqSigned,
    input  logic [31:0] ReqPC,
    output logic        RespValid,
    input  logic        RespReady,
    output logic [31:0] RespRData,
    output logic        RespErr
);

    localparam int                IDX_W     = $clog2(ADDR_WORDS);
    localparam logic [31:0]       SPAN      = 32'(ADDR_WORDS * 4);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

    dm_state_e         state_r;
    logic [WAIT_W-1:0] cnt_r;
    logic              write_r;
    logic [31:0]       addr_r;
    logic [31:0]       wdata_r;
    logic [1:0]        width_r;
    logic              signed_r;
    logic [31:0]       pc_r;
    logic              resp_valid_r;
    logic [31:0]       rdata_r;
    logic              err_r;
    logic [31:0]       mem_r [ADDR_WORDS];

    logic [31:0]       off_s;
    logic [IDX_W-1:0]  idx_s;
    logic              err_s;
    logic [31:0]       merged_s;
    logic [31:0]       load_s;

    // Decode the latched request; wrapping subtraction makes sub-base addresses fail.
    always_comb begin
        off_s = addr_r - BASE_ADDR;
        idx_s = off_s[IDX_W+1:2];
        err_s = (width_r == 2'd3)
             || ((width_r == MEM_W_HALF) && addr_r[0])
             || ((width_r == MEM_W_WORD) && (addr_r[1:0] != 2'b00))
             || (off_s >= SPAN);
    end

    dm_lane_align u_align (
        .word     (mem_r[idx_s]),
        .wdata    (wdata_r),
        .lane     (addr_r[1:0]),
        .width    (width_r),
        .sign_ext (signed_r),
        .merged   (merged_s),
        .rdata    (load_s)
    );

    // Request FSM, wait counter, storage and response registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            write_r      <= 1'b0;
            addr_r       <= 32'h0;
            wdata_r      <= 32'h0;
            width_r      <= 2'd0;
            signed_r     <= 1'b0;
            pc_r         <= 32'h0;
            resp_valid_r <= 1'b0;
            rdata_r      <= 32'h0;
            err_r        <= 1'b0;
            for (int i = 0; i < ADDR_WORDS; i++) mem_r[i] <= 32'h0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ReqValid) begin
                        write_r  <= ReqWrite;
                        addr_r   <= ReqAddr;
                        wdata_r  <= ReqWData;
                        width_r  <= ReqWidth;
                        signed_r <= ReqSigned;
                        pc_r     <= ReqPC;
                        cnt_r    <= WAIT_INIT;
                        state_r  <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_r != '0) begin
                        cnt_r <= cnt_r - 1'b1;
                    end else begin
                        if (write_r && !err_s) mem_r[idx_s] <= merged_s;
                        rdata_r      <= (write_r || err_s) ? 32'h0 : load_s;
                        err_r        <= err_s;
                        resp_valid_r <= 1'b1;
                        state_r      <= RESP;
                    end
                end
                RESP: begin
                    if (RespReady) begin
                        resp_valid_r <= 1'b0;
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    resp_valid_r <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

`ifdef DM_WRITE_TRACE_EN
    // Trace each committed, error-free store in the GRF/DM format.
    always_ff @(posedge Clk) begin
        if (Reset && (state_r == BUSY) && (cnt_r == '0) && write_r && !err_s)
            $display("@%h: *%h <= %h", pc_r, {addr_r[31:2], 2'b00}, merged_s);
    end
`else
    logic unused_pc_s;
    assign unused_pc_s = ^pc_r;
`endif

    assign ReqReady  = (state_r == IDLE) && Reset;
    assign RespValid = resp_valid_r;
    assign RespRData = rdata_r;
    assign RespErr   = err_r;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed vector table, hand-written
// backpressure/reset sequences, and randomized traffic against a byte model.
module tb_dm_responder;

    localparam int          WAIT  = 2;
    localparam int          WORDS = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ReqValid, ReqReady, ReqWrite, ReqSigned;
    logic [31:0] ReqAddr, ReqWData, ReqPC;
    logic [1:0]  ReqWidth;
    logic        RespValid, RespReady, RespErr;
    logic [31:0] RespRData;

    int checks = 0;
    int passed = 0;

    logic [7:0] mbytes [WORDS*4];

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  wd;
        logic        s;
        logic [31:0] exp_rd;
        logic        exp_er;
    } vec_t;

    vec_t tbl [21];

    dm_responder #(.ADDR_WORDS(WORDS), .BASE_ADDR(BASE), .WAIT_CYCLES(WAIT)) dut (
        .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqWrite(ReqWrite), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
        .ReqWidth(ReqWidth), .ReqSigned(ReqSigned), .ReqPC(ReqPC),
        .RespValid(RespValid), .RespReady(RespReady),
        .RespRData(RespRData), .RespErr(RespErr)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [1:0] wd, input logic s,
                                input logic [31:0] rd, input logic er);
        vec_t v;
        v.w = w; v.a = a; v.d = d; v.wd = wd; v.s = s; v.exp_rd = rd; v.exp_er = er;
        return v;
    endfunction

    // Behavioural reference: byte-addressed little-endian storage.
    task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [1:0] wd, input logic s,
                                output logic [31:0] rd, output logic er);
        logic [31:0] off;
        logic [31:0] val;
        int n;
        n   = (wd == 2'd0) ? 4 : (wd == 2'd1) ? 2 : 1;
        off = a - BASE;
        er  = (wd == 2'd3) || ((a % n) != 0) || (off >= WORDS * 4);
        rd  = 32'h0;
        if (!er) begin
            if (w) begin
                for (int i = 0; i < n; i++) mbytes[off + i] = 8'((d >> (8 * i)) & 32'hFF);
            end else begin
                val = 32'h0;
                for (int i = 0; i < n; i++) val = val | (32'(mbytes[off + i]) << (8 * i));
                if (s && n < 4 && ((val >> (8 * n - 1)) & 32'h1) == 32'h1)
                    val = val | ~((32'h1 << (8 * n)) - 32'h1);
                rd = val;
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < WORDS * 4; i++) mbytes[i] = 8'h00;
    endtask

    // Present a request and return just after the accepting edge.
    task automatic start_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] wd, input logic s);
        int n;
        ReqWrite = w; ReqAddr = a; ReqWData = d; ReqWidth = wd; ReqSigned = s;
        ReqPC = $urandom; ReqValid = 1'b1;
        n = 0;
        while (!ReqReady && n < 20) begin @(posedge Clk); #1; n++; end
        if (!ReqReady) timeout_fail("req_accept");
        @(posedge Clk); #1;
        ReqValid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (!RespValid && lat < 40) begin @(posedge Clk); #1; lat++; end
        if (!RespValid) timeout_fail("resp_wait");
    endtask

    task automatic do_op(input string name, input vec_t v, input logic use_model, input int hold);
        logic [31:0] mrd, rd, exp_rd;
        logic        mer, er, exp_er;
        int lat;
        model_access(v.w, v.a, v.d, v.wd, v.s, mrd, mer);
        exp_rd = use_model ? mrd : v.exp_rd;
        exp_er = use_model ? mer : v.exp_er;
        start_req(v.w, v.a, v.d, v.wd, v.s);
        wait_resp(lat);
        rd = RespRData; er = RespErr;
        repeat (hold) begin @(posedge Clk); #1; end
        RespReady = 1'b1;
        @(posedge Clk); #1;
        RespReady = 1'b0;
        check({name, "_latency"}, 32'(lat), 32'(WAIT + 1));
        check({name, "_rdata"}, rd, exp_rd);
        check({name, "_err"}, 32'(er), 32'(exp_er));
    endtask

    initial begin
        logic [31:0] ra, rd0;
        vec_t v;
        int lat;

        tbl[0]  = mk(1'b0, 32'h10,  32'h0,        2'd0, 1'b0, 32'h0000_0000, 1'b0);
        tbl[1]  = mk(1'b1, 32'h10,  32'h12345678, 2'd0, 1'b0, 32'h0000_0000, 1'b0);
        tbl[2]  = mk(1'b0, 32'h10,  32'h0,        2'd0, 1'b0, 32'h12345678,  1'b0);
        tbl[3]  = mk(1'b1, 32'h13,  32'h123456AB, 2'd2, 1'b0, 32'h0000_0000, 1'b0);
        tbl[4]  = mk(1'b0, 32'h10,  32'h0,        2'd0, 1'b0, 32'hAB345678,  1'b0);
        tbl[5]  = mk(1'b0, 32'h13,  32'h0,        2'd2, 1'b1, 32'hFFFF_FFAB, 1'b0);
        tbl[6]  = mk(1'b0, 32'h13,  32'h0,        2'd2, 1'b0, 32'h0000_00AB, 1'b0);
        tbl[7]  = mk(1'b1, 32'h12,  32'hCAFE8001, 2'd1, 1'b1, 32'h0000_0000, 1'b0);
        tbl[8]  = mk(1'b0, 32'h12,  32'h0,        2'd1, 1'b1, 32'hFFFF_8001, 1'b0);
        tbl[9]  = mk(1'b0, 32'h12,  32'h0,        2'd1, 1'b0, 32'h0000_8001, 1'b0);
        tbl[10] = mk(1'b0, 32'h10,  32'h0,        2'd1, 1'b1, 32'h0000_5678, 1'b0);
        tbl[11] = mk(1'b0, 32'h10,  32'h0,        2'd0, 1'b0, 32'h80015678,  1'b0);
        tbl[12] = mk(1'b0, 32'h12,  32'h0,        2'd0, 1'b0, 32'h0000_0000, 1'b1);
        tbl[13] = mk(1'b1, 32'h1000, 32'hFFFFFFFF, 2'd0, 1'b0, 32'h0000_0000, 1'b1);
        tbl[14] = mk(1'b0, 32'h0,   32'h0,        2'd0, 1'b0, 32'h0000_0000, 1'b0);
        tbl[15] = mk(1'b0, 32'h10,  32'h0,        2'd3, 1'b0, 32'h0000_0000, 1'b1);
        tbl[16] = mk(1'b1, 32'h11,  32'h0000FFFF, 2'd1, 1'b0, 32'h0000_0000, 1'b1);
        tbl[17] = mk(1'b0, 32'h10,  32'h0,        2'd0, 1'b0, 32'h80015678,  1'b0);
        tbl[18] = mk(1'b0, 32'h10,  32'h0,        2'd2, 1'b1, 32'h0000_0078, 1'b0);
        tbl[19] = mk(1'b1, 32'hFFF, 32'h0000005A, 2'd2, 1'b0, 32'h0000_0000, 1'b0);
        tbl[20] = mk(1'b0, 32'hFFC, 32'h0,        2'd0, 1'b0, 32'h5A00_0000, 1'b0);

        Reset = 1'b0; ReqValid = 1'b0; RespReady = 1'b0; ReqWrite = 1'b0;
        ReqAddr = 32'h0; ReqWData = 32'h0; ReqWidth = 2'd0; ReqSigned = 1'b0; ReqPC = 32'h0;
        model_clear();
        #2;
        check("rst_req_ready", 32'(ReqReady), 32'h0);
        check("rst_resp_valid", 32'(RespValid), 32'h0);
        check("rst_rdata", RespRData, 32'h0);
        check("rst_err", 32'(RespErr), 32'h0);
        repeat (2) @(posedge Clk);
        #3 Reset = 1'b1;
        @(posedge Clk); #1;
        check("post_rst_req_ready", 32'(ReqReady), 32'h1);

        for (int i = 0; i < 21; i++) do_op($sformatf("vec%0d", i), tbl[i], 1'b0, 0);

        // Backpressure: response held 5 cycles while the next request waits.
        model_access(1'b0, 32'h10, 32'h0, 2'd0, 1'b0, rd0, v.exp_er);
        start_req(1'b0, 32'h10, 32'h0, 2'd0, 1'b0);
        wait_resp(lat);
        ReqWrite = 1'b0; ReqAddr = 32'h12; ReqWidth = 2'd2; ReqSigned = 1'b0; ReqValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk); #1;
            check("bp_resp_valid", 32'(RespValid), 32'h1);
            check("bp_rdata", RespRData, 32'h80015678);
            check("bp_err", 32'(RespErr), 32'h0);
            check("bp_req_ready", 32'(ReqReady), 32'h0);
        end
        RespReady = 1'b1;
        @(posedge Clk); #1;
        RespReady = 1'b0;
        check("bp_after_hs_ready", 32'(ReqReady), 32'h1);
        check("bp_after_hs_valid", 32'(RespValid), 32'h0);
        @(posedge Clk); #1;
        check("bp_next_accepted", 32'(ReqReady), 32'h0);
        ReqValid = 1'b0;
        wait_resp(lat);
        check("bp_next_latency", 32'(lat), 32'(WAIT + 1));
        check("bp_next_rdata", RespRData, 32'h0000_0001);
        RespReady = 1'b1;
        @(posedge Clk); #1;
        RespReady = 1'b0;

        // Reset while a store is waiting in BUSY: the store must never land.
        start_req(1'b1, 32'h20, 32'hDEADBEEF, 2'd0, 1'b0);
        @(posedge Clk); #1;
        #2 Reset = 1'b0;
        #1;
        check("midrst_req_ready", 32'(ReqReady), 32'h0);
        check("midrst_resp_valid", 32'(RespValid), 32'h0);
        @(posedge Clk);
        #3 Reset = 1'b1;
        model_clear();
        @(posedge Clk); #1;
        check("midrst_after_valid", 32'(RespValid), 32'h0);
        check("midrst_after_ready", 32'(ReqReady), 32'h1);
        do_op("midrst_load20", mk(1'b0, 32'h20, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0), 1'b0, 0);
        do_op("midrst_load10", mk(1'b0, 32'h10, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0), 1'b0, 0);

        // Randomized traffic against the byte model.
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0:       ra = $urandom;
                1:       ra = 32'h1000 - 32'($urandom_range(1, 8));
                default: ra = 32'($urandom_range(0, 63));
            endcase
            v = mk(1'($urandom_range(0, 1)), ra, $urandom, 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 32'h0, 1'b0);
            do_op("rand", v, 1'b1, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
# dm_responder

Memory-side responder for the processor's data-memory port. It accepts one load or store request at a time over a valid/ready handshake and holds it for a programmable number of wait states. It then performs the byte, half or word access with lane alignment and sign or zero extension, and returns data plus an error flag over a second valid/ready handshake. It replaces the zero-latency data memory when the core moves to a stallable memory interface.

## Interface
Parameters:
- ADDR_WORDS, 1024: storage depth in 32-bit words (4 KiB).
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- WAIT_CYCLES, 1: extra cycles between accept and commit; legal range 0..15.

Ports:
- Clk  in  1  clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  responder can accept a request.
- ReqWrite  in  1  1 = store, 0 = load.
- ReqAddr  in  32  byte address.
- ReqWData  in  32  store data, right-aligned.
- ReqWidth  in  2  0 = word, 1 = half, 2 = byte, 3 = illegal.
- ReqSigned  in  1  sign-extend load; ignored for word and for stores.
- ReqPC  in  32  PC of the issuing instruction, used for trace only.
- RespValid  out  1  response present.
- RespReady  in  1  requester takes the response.
- RespRData  out  32  load data; 0 for stores and errors.
- RespErr  out  1  request was rejected.

## Operation
- FSM states:
  - IDLE: ReqReady=1. When ReqValid&&ReqReady at a rising edge, latch all Req* fields, load the counter with WAIT_CYCLES, and go to BUSY.
  - BUSY: ReqReady=0. If the counter is nonzero, decrement it. If the counter is 0, commit the access, register RespRData and RespErr, and go to RESP.
  - RESP: RespValid=1. RespRData and RespErr stay stable. When RespValid&&RespReady at an edge, go to IDLE.
- ReqValid in BUSY or RESP is ignored; the requester must hold it.
- Error checks use the latched request. The flag is set on any of:
  - ReqWidth==3.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - addr-BASE_ADDR >= ADDR_WORDS*4, using unsigned 32-bit subtraction so addresses below base wrap and fail.
- On error: no memory write, RespRData=0, RespErr=1.
- Word index is (addr-BASE_ADDR)[.. :2].
- Stores:
  - Byte writes lane addr[1:0] with WData[7:0].
  - Half writes lane addr[1] with WData[15:0].
  - Word writes all 32 bits.
  - Other lanes are preserved.
- Loads:
  - Extract the lane selected by the address.
  - Sign-extend if ReqSigned, otherwise zero-extend.
- Store responses: RespRData=0, RespErr=0.

## Timing
- Request accepted at edge k. The commit happens at edge k+1+WAIT_CYCLES, and RespValid is high from that edge on.
- With WAIT_CYCLES=0, RespValid rises one cycle after accept.
- Response handshake at edge m returns the FSM to IDLE. ReqReady is 1 from edge m, so the earliest next accept is edge m+1.
- Peak throughput: one request per WAIT_CYCLES+3 cycles.
- Reset (Reset=0) forces, immediately and independently of Clk:
  - state IDLE, counter 0;
  - RespValid=0, RespRData=0, RespErr=0;
  - all memory words 0;
  - ReqReady=0 while Reset is low, returning to 1 after release.
- Reset mid-operation drops the pending request. A store not yet committed never takes effect.

## Configuration
- DM_WRITE_TRACE_EN defined: each committed, non-error store prints one line, "@<ReqPC hex>: *<word-aligned address hex> <= <new full word hex>", matching the GRF/DM trace format.
- DM_WRITE_TRACE_EN undefined: no simulation output. ReqPC is still present but unused.

## Structure
- Shared package mem_pkg holds:
  - the width encoding constants (MEM_W_WORD=0, MEM_W_HALF=1, MEM_W_BYTE=2);
  - the FSM state enum (IDLE, BUSY, RESP);
  - the WAIT_CYCLES width constant (4 bits).
- One combinational sub-module, dm_lane_align, handles both directions:
  - store path: given old word, addr[1:0], width and data, produces the merged word;
  - load path: given word, addr[1:0], width and signed, produces the extended data.
- The FSM, counter, storage and error check stay in dm_responder.

## Test plan
- Reset, WAIT_CYCLES=2: store word 0x12345678 at 0x10, then load word 0x10 → RespValid exactly 3 cycles after each accept; RData=0x12345678, Err=0.
- Store byte 0xAB at 0x13, then:
  - load word 0x10 → 0xAB345678;
  - load byte 0x13 signed → 0xFFFFFFAB;
  - load byte 0x13 unsigned → 0x000000AB.
- Store half 0x8001 at 0x12, then:
  - load half signed → 0xFFFF8001;
  - load half unsigned → 0x00008001;
  - load half 0x10 → 0x5678.
- Error cases:
  - load word 0x12 → Err=1, RData=0;
  - store word at 0x1000 (ADDR_WORDS=1024) → Err=1, and a later load of word 0 is unchanged;
  - ReqWidth=3 → Err=1.
- RespReady held low 5 cycles → RespValid, RData and Err stable; ReqReady=0; a new ReqValid is not accepted until one cycle after the response handshake.
- Reset pulsed while a store of 0xDEADBEEF to 0x20 is in BUSY → after release, RespValid=0, ReqReady=1, and a load of 0x20 returns 0.
